// File: rtl/rom_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_reader_pkg                                                       |
// | Shared ROM reader widths, access timing default and state encoding.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rom_reader_pkg;

    localparam int c_ADDR_WIDTH    = 9;
    localparam int c_DATA_WIDTH    = 8;
    localparam int c_ACCESS_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Chip select is held through the whole read of a word.
    function automatic logic f_cs_active(input state_e s);
        return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_HANDOFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_read_sequencer_access_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | access_timer                                                         |
// | 8-bit load/count counter flagging the terminal access cycle.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module access_timer #(
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_terminal
);

    localparam logic [7:0] c_TC = 8'(TERMINAL);

    logic [7:0] r_count_q;
    logic [7:0] w_count_d;

    assign o_terminal = (r_count_q == c_TC);

    // Saturate at terminal so a stalled count never wraps.
    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = '0;
        end else if (i_count && !o_terminal) begin
            w_count_d = r_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_read_sequencer                                                   |
// | Walks the ROM address space and streams each word over valid/ready.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rom_read_sequencer
    import rom_reader_pkg::*;
#(
    parameter int ADDR_WIDTH    = c_ADDR_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int ACCESS_CYCLES = c_ACCESS_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] last_address,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs_n,
    output logic                  rom_oe_n,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic [ADDR_WIDTH-1:0] current_address,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                r_state_q,   w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,    w_addr_d;
    logic [ADDR_WIDTH-1:0] r_last_q,    w_last_d;
    logic [DATA_WIDTH-1:0] r_data_q,    w_data_d;
    logic                  r_cs_n_q,    w_cs_n_d;
    logic                  r_oe_n_q,    w_oe_n_d;
    logic                  r_valid_q,   w_valid_d;
    logic                  r_busy_q,    w_busy_d;
    logic                  r_done_q,    w_done_d;
    logic                  w_timer_terminal;

    access_timer #(
        .TERMINAL (ACCESS_CYCLES - 1)
    ) u_access_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (r_state_q == ST_SETUP),
        .i_count    (r_state_q == ST_ACCESS),
        .o_terminal (w_timer_terminal)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_last_d  = r_last_q;
        w_data_d  = r_data_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_d = ST_SETUP;
                    w_addr_d  = '0;
                    w_last_d  = last_address;
                end
            end
            ST_SETUP: w_state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (w_timer_terminal) begin
                    w_data_d  = rom_data;
                    w_state_d = ST_HANDOFF;
                end
            end
            ST_HANDOFF: begin
                // Compare before incrementing so the top address never wraps.
                if (data_ready) begin
                    if (r_addr_q == r_last_q) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_SETUP;
                        w_addr_d  = r_addr_q + c_ADDR_ONE;
                    end
                end
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase

        if (abort && (r_state_q != ST_IDLE)) begin
            w_state_d = ST_IDLE;
            w_addr_d  = '0;
            w_data_d  = r_data_q;
        end

        // Outputs are decoded from the next state so every pin comes off a flop.
        w_cs_n_d  = !f_cs_active(w_state_d);
        w_oe_n_d  = (w_state_d != ST_ACCESS);
        w_valid_d = (w_state_d == ST_HANDOFF);
        w_busy_d  = (w_state_d != ST_IDLE);
        w_done_d  = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_last_q  <= '0;
            r_data_q  <= '0;
            r_cs_n_q  <= 1'b1;
            r_oe_n_q  <= 1'b1;
            r_valid_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_last_q  <= w_last_d;
            r_data_q  <= w_data_d;
            r_cs_n_q  <= w_cs_n_d;
            r_oe_n_q  <= w_oe_n_d;
            r_valid_q <= w_valid_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign rom_address     = r_addr_q;
    assign current_address = r_addr_q;
    assign rom_cs_n        = r_cs_n_q;
    assign rom_oe_n        = r_oe_n_q;
    assign data_out        = r_data_q;
    assign data_valid      = r_valid_q;
    assign busy            = r_busy_q;
    assign done            = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_read_sequencer                                                |
// | Directed and randomized dumps against a cycle-timeline ROM model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rom_read_sequencer;

    localparam int AC = 4;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, data_ready;
    logic [AW-1:0] last_address;
    logic [AW-1:0] rom_address, current_address;
    logic          rom_cs_n, rom_oe_n, data_valid, busy, done;
    logic [DW-1:0] rom_data, data_out;

    logic [DW-1:0] mem [0:511];
    int            oe_run = 0;
    int            checks = 0;
    int            errors = 0;

    rom_read_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .last_address    (last_address),
        .rom_address     (rom_address),
        .rom_cs_n        (rom_cs_n),
        .rom_oe_n        (rom_oe_n),
        .rom_data        (rom_data),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .current_address (current_address),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // ROM only presents the true word once OE has been low for the full access time.
    always @(posedge clk) oe_run <= rom_oe_n ? 0 : oe_run + 1;
    assign rom_data = (!rom_oe_n && oe_run >= AC - 1) ? mem[rom_address] : ~mem[rom_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", data_valid, 0);
        check("rst_cs_n", rom_cs_n, 1);
        check("rst_oe_n", rom_oe_n, 1);
        check("rst_addr", rom_address, 0);
        check("rst_cur_addr", current_address, 0);
        check("rst_data_out", data_out, 0);
    endtask

    // Cycle n is the interval following the (n-1)th edge after start is sampled.
    task automatic run_dump(input int last, input int ready_pct, input bit addr_pattern,
                            input int stall_idx, input int abort_idx, input int reset_idx);
        int  idx    = 0;
        int  h_prev = 0;
        int  last_h = -1;
        int  c      = 0;
        int  stall  = 10;
        int  budget = (last + 1) * (AC + 2 + 60) + 20;
        bit  fin    = 0;
        bit  exp_valid;
        bit  exp_oe_n;
        for (int i = 0; i < 512; i++) mem[i] = addr_pattern ? 8'(i) : 8'($urandom);

        start        = 1'b1;
        last_address = AW'(last);
        @(negedge clk);
        start = 1'b0;
        c     = 1;
        while (!fin && c < budget) begin
            if (last_h < 0) begin
                exp_valid = (c >= h_prev + AC + 2);
                exp_oe_n  = !(c >= h_prev + 2 && c <= h_prev + AC + 1);
                check("busy", busy, 1);
                check("done_early", done, 0);
                check("data_valid", data_valid, exp_valid);
                check("rom_oe_n", rom_oe_n, exp_oe_n);
                check("rom_cs_n", rom_cs_n, 0);
                check("rom_address", rom_address, idx);
                check("current_address", current_address, idx);
                if (exp_valid) check("data_out", data_out, mem[idx]);

                if (idx == abort_idx && c == h_prev + 3) begin
                    abort = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_busy", busy, 0);
                    check("abort_valid", data_valid, 0);
                    check("abort_addr", rom_address, 0);
                    check("abort_cur_addr", current_address, 0);
                    check("abort_cs_n", rom_cs_n, 1);
                    check("abort_oe_n", rom_oe_n, 1);
                    for (int k = 0; k < 3; k++) begin
                        check("abort_no_done", done, 0);
                        @(negedge clk);
                    end
                    return;
                end
                if (idx == reset_idx && exp_valid) begin
                    reset = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    check_idle_reset_values();
                    reset = 1'b0;
                    return;
                end

                if (idx == stall_idx && exp_valid && stall > 0) begin
                    data_ready = 1'b0;
                    stall--;
                end else begin
                    data_ready = ($urandom_range(1, 100) <= ready_pct);
                end
                start = ($urandom_range(0, 7) == 0);
                if (exp_valid && data_ready) begin
                    h_prev = c;
                    idx++;
                    if (idx > last) last_h = c;
                end
            end else if (c == last_h + 1) begin
                start = 1'b0;
                check("done_pulse", done, 1);
                check("done_busy", busy, 1);
                check("done_valid", data_valid, 0);
                check("done_cs_n", rom_cs_n, 1);
                check("done_oe_n", rom_oe_n, 1);
                check("done_addr", rom_address, last);
                if (ready_pct == 100 && stall_idx < 0)
                    check("done_cycle", c, (last + 1) * (AC + 2) + 1);
            end else begin
                check("end_busy", busy, 0);
                check("end_done", done, 0);
                check("end_cs_n", rom_cs_n, 1);
                check("end_addr_kept", rom_address, last);
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        check("dump_completed", fin, 1);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        data_ready   = 1'b0;
        last_address = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // start together with abort in IDLE must not launch a dump
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_cs_n", rom_cs_n, 1);
        @(negedge clk);
        check("start_abort_still_idle", busy, 0);

        run_dump(511, 100, 1'b1, -1, -1, -1);
        run_dump(0,   100, 1'b0, -1, -1, -1);
        run_dump(20,  100, 1'b0,  5, -1, -1);
        run_dump(60,   70, 1'b0, -1, 37, -1);
        run_dump(10,   60, 1'b0, -1, -1,  3);
        run_dump(15,   50, 1'b0, -1, -1, -1);
        for (int t = 0; t < 3; t++)
            run_dump(int'($urandom_range(1, 40)), int'($urandom_range(30, 100)), 1'b0, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

Sequences a full dump of the parallel ROM under test: walks the address bus from 0 to a configurable last address, drives chip-select/output-enable with a programmable access time, latches each data word and hands it to a downstream consumer (UART/FIFO) over a valid/ready handshake. Its `current_address` output feeds the seven-segment address display, so the operator sees the word being read. It sits between the board-level ROM socket pins and the transfer path.

## Interface
- `ADDR_WIDTH`, 9: ROM address bus width.
- `DATA_WIDTH`, 8: ROM data bus width.
- `ACCESS_CYCLES`, 4: clocks `rom_oe_n` is held low before data is sampled; legal range 1..255.
- `clk`  in  1  system clock; the block is single-clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `abort`  in  1  terminate a dump in progress.
- `last_address`  in  ADDR_WIDTH  final address to read, inclusive; sampled on the accepted `start`.
- `rom_address`  out  ADDR_WIDTH  address bus to the ROM.
- `rom_cs_n`  out  1  ROM chip select, active low.
- `rom_oe_n`  out  1  ROM output enable, active low.
- `rom_data`  in  DATA_WIDTH  ROM data bus.
- `data_out`  out  DATA_WIDTH  latched word.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word.
- `current_address`  out  ADDR_WIDTH  address of the word in flight, for the display.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, SETUP, ACCESS, HANDOFF, DONE.
- IDLE: `rom_cs_n`=1, `rom_oe_n`=1. `start`=1 and `abort`=0 → SETUP; `rom_address` ← 0; `last_address` is captured into an internal register.
- SETUP (1 cycle): `rom_cs_n`=0, `rom_oe_n`=1, address stable → ACCESS; access counter ← 0.
- ACCESS: `rom_cs_n`=0, `rom_oe_n`=0. The counter increments each cycle. On the cycle with counter = `ACCESS_CYCLES`−1, `data_out` ← `rom_data` and the block moves to HANDOFF.
- HANDOFF: `data_valid`=1, `rom_oe_n`=1, `rom_cs_n`=0. `data_out` is held stable until `data_valid`&&`data_ready`. On that handshake:
  - if address = captured last address → DONE;
  - otherwise address+1 → SETUP.
- DONE (1 cycle): `done`=1, `rom_cs_n`=1 → IDLE. `rom_address` keeps the last value.
- `abort` in any non-IDLE state → IDLE next cycle. `data_valid` drops, the pending word is discarded, `rom_address` ← 0, and `done` does not pulse.
- `start` outside IDLE is ignored. When `start` and `abort` arrive together in IDLE, `abort` wins.
- `current_address` always equals `rom_address`.
- Address arithmetic is ADDR_WIDTH-bit unsigned. With `last_address` = 2^ADDR_WIDTH−1 the sequence ends at that address and never wraps. With `last_address` = 0 exactly one word is read.

## Timing
- Reset values: `rom_address` 0, `rom_cs_n` 1, `rom_oe_n` 1, `data_out` 0, `data_valid` 0, `current_address` 0, `busy` 0, `done` 0, state IDLE.
- Reset asserted mid-dump returns everything to the reset values on the next edge.
- All outputs are registered, with no combinational path from input to output.
- Cycle timing with `start` sampled at edge 0:
  - SETUP in cycle 1;
  - ACCESS in cycles 2..1+`ACCESS_CYCLES`;
  - `data_valid` first high in cycle 2+`ACCESS_CYCLES`.
- Per-word period with `data_ready` held high is `ACCESS_CYCLES`+2 cycles. `data_valid` therefore never stays high two consecutive cycles in that case.
- `done` rises the cycle after the final handshake. `busy` falls the cycle after `done`.
- `rom_address` changes only on the edge that enters SETUP or IDLE, never while `rom_oe_n`=0.

## Structure
- A shared `rom_reader_pkg` package (or include file) holds:
  - state encodings;
  - default `ADDR_WIDTH`/`DATA_WIDTH`, which are common with the address display;
  - the default `ACCESS_CYCLES`.
- One sub-module, `access_timer`: an 8-bit load/count/terminal-count counter used by ACCESS.

## Test plan
- Full dump, `last_address`=511, `ACCESS_CYCLES`=4, ROM model returns address[7:0], `data_ready`=1 → 512 words 0x00..0xFF repeating, in order; `done` at cycle 3073 after `start`.
- `last_address`=0 → one word, one `data_valid` cycle, `done` 1 cycle later, `rom_address` stays 0.
- Backpressure: `data_ready` low for 10 cycles on word 5 → `data_out`, `rom_address`=5 and `data_valid` held; no OE activity until accepted.
- `abort` during ACCESS of address 37 → IDLE next cycle, `data_valid`=0, `rom_address`=0, no `done`.
- `start` and `abort` together in IDLE → remains IDLE. `start` pulsed while busy → no effect on the sequence.
- `reset` asserted during HANDOFF → all outputs at reset values next cycle; a subsequent `start` begins again at address 0.
